// File: rtl/cursor_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cursor_axi_pkg
// Brief   : Shared constants, state encodings and the address decoder for the
//           cursor overlay AXI4-Lite register front-end.
// Revision: 1.0 - initial release
// ============================================================================
package cursor_axi_pkg;

    // Address map (byte addresses within the 7-bit decoded window)
    localparam logic [6:0] CURPOS_ADDR = 7'h00;
    localparam logic [6:0] CURIMG_BASE = 7'h40;
    localparam logic [6:0] CURIMG_MASK = 7'h40;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write channel state machine
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DO   = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    // Read channel state machine
    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Decoded target of an access
    typedef enum logic [1:0] {
        HIT_NONE = 2'd0,
        HIT_POS  = 2'd1,
        HIT_IMG  = 2'd2
    } hit_t;

    // Classify a word address. upper_zero is true when every address bit
    // above bit 6 is clear; word is addr[6:2] (byte lanes are ignored).
    function automatic hit_t decode(input logic upper_zero, input logic [4:0] word);
        hit_t h;
        h = HIT_NONE;
        if (upper_zero) begin
            if (word == CURPOS_ADDR[6:2]) begin
                h = HIT_POS;
            end else if ((word & CURIMG_MASK[6:2]) == CURIMG_BASE[6:2]) begin
                h = HIT_IMG;
            end
        end
        return h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cursor_axi.sv
`default_nettype none
// ============================================================================
// Module  : cursor_axi
// Brief   : AXI4-Lite slave driving the cursor position register and the
//           cursor image write port. Independent read and write engines, one
//           outstanding transaction per direction, single clock domain.
// Revision: 1.0 - initial release
// ============================================================================
module cursor_axi
    import cursor_axi_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    // write address
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    // write data
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wvalid,
    output logic              wready,
    // write response
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    // read address
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    // read data
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    // cursor outputs
    output logic [31:0]       curreg,
    output logic [5:0]        curaddr,
    output logic [31:0]       curwdata,
    output logic [3:0]        curwstrb,
    output logic              curreq
);

    wr_state_t         wstate;
    rd_state_t         rstate;

    logic              aw_held;
    logic              w_held;
    logic [ADDR_W-1:0] awaddr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;

    logic              aw_fire;
    logic              w_fire;
    logic [ADDR_W-1:0] addr_cur;
    logic [31:0]       wdata_cur;
    logic [3:0]        wstrb_cur;
    hit_t              hit_cur;
    hit_t              hit_held;
    hit_t              hit_ar;
    logic              unused_ar_lanes;

    // Ready flags come straight from the idle state so the first cycle after
    // reset can already accept; they are forced low while reset is applied.
    assign awready = (wstate == W_IDLE) && !aw_held && !rst;
    assign wready  = (wstate == W_IDLE) && !w_held  && !rst;
    assign arready = (rstate == R_IDLE) && !rst;

    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid  && wready;

    // The half arriving in this very cycle bypasses its holding register so
    // the image strobe can be issued on the edge that completes the pair.
    assign addr_cur  = aw_held ? awaddr_q : awaddr;
    assign wdata_cur = w_held  ? wdata_q  : wdata;
    assign wstrb_cur = w_held  ? wstrb_q  : wstrb;

    assign hit_cur  = decode((addr_cur >> 7) == '0, addr_cur[6:2]);
    assign hit_held = decode((awaddr_q >> 7) == '0, awaddr_q[6:2]);
    assign hit_ar   = decode((araddr   >> 7) == '0, araddr[6:2]);

    assign unused_ar_lanes = &{1'b0, araddr[1:0]};

    // Write engine: collect AW and W in either order, perform the access for
    // one cycle, then hold the response until the master accepts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate   <= W_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            curreg   <= '0;
            curaddr  <= '0;
            curwdata <= '0;
            curwstrb <= '0;
            curreq   <= 1'b0;
        end else begin
            curreq <= 1'b0;
            case (wstate)
                W_IDLE: begin
                    if (aw_fire) begin
                        aw_held  <= 1'b1;
                        awaddr_q <= awaddr;
                    end
                    if (w_fire) begin
                        w_held  <= 1'b1;
                        wdata_q <= wdata;
                        wstrb_q <= wstrb;
                    end
                    if ((aw_held || aw_fire) && (w_held || w_fire)) begin
                        wstate <= W_DO;
                        if (hit_cur == HIT_IMG) begin
                            curreq   <= 1'b1;
                            curaddr  <= addr_cur[5:0];
                            curwdata <= wdata_cur;
                            curwstrb <= wstrb_cur;
                        end
                    end
                end
                W_DO: begin
                    if (hit_held == HIT_POS) begin
                        for (int i = 0; i < 4; i++) begin
                            if (wstrb_q[i]) begin
                                curreg[8*i +: 8] <= wdata_q[8*i +: 8];
                            end
                        end
                    end
                    bresp  <= (hit_held == HIT_NONE) ? RESP_SLVERR : RESP_OKAY;
                    bvalid <= 1'b1;
                    wstate <= W_RESP;
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        wstate  <= W_IDLE;
                    end
                end
                default: begin
                    wstate <= W_IDLE;
                end
            endcase
        end
    end

    // Read engine: sample the register file at the AR handshake and hold the
    // beat until the master takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate <= R_IDLE;
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (arvalid) begin
                        rdata  <= (hit_ar == HIT_POS) ? curreg : 32'd0;
                        rresp  <= (hit_ar == HIT_NONE) ? RESP_SLVERR : RESP_OKAY;
                        rvalid <= 1'b1;
                        rstate <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        rstate <= R_IDLE;
                    end
                end
                default: begin
                    rstate <= R_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
